mips_spi_master: RTL and testbench
==================================

# mips_spi_master

Memory-mapped SPI master peripheral for the MIPS SoC. It gives the CPU a way to initiate SPI transfers to external slaves, complementing the existing SPI slave port. The MMU decodes its address pair (0x0000_C300 DATA, 0x0000_C304 CTRL/STATUS) and feeds it the shared bus. Each transfer is one byte, full-duplex, SPI mode 0, MSB first, with a programmable SCK rate.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per SCK half-period; legal range ≥1.

Ports:
- clk  in  1  SoC clock (same as CPU/MMU).
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- sel  in  1  MMU address decode for this block.
- rdWR  in  1  0 = CPU read, 1 = CPU write (MMU convention).
- reg_addr  in  1  ADDR[2]: 0 = DATA, 1 = CTRL/STATUS.
- data_in  in  32  write data from CPU; only [7:0] used.
- data_out  out  32  read data to MMU mux, zero-extended.
- SCK  out  1  serial clock, idles low.
- MOSI  out  1  master out.
- MISO  in  1  master in; synchronous to SCK, sampled in clk domain.
- nCS  out  1  active-low slave select.
- busy  out  1  transfer in progress.

## Operation
- Bus accesses are level signals held by the CPU. Each access is edge-detected: an access is accepted only on the first cycle its (sel, rdWR, reg_addr) combination becomes true.
- Write DATA while idle: latches data_in[7:0] into the shift register, clears wcol, and starts a transfer.
- Write DATA while busy: the write is ignored and STATUS.wcol is set.
- Write CTRL: bit0 = hold_cs. When 1, nCS stays low after a transfer. Writing 0 while idle drives nCS high on the next cycle.
- Read DATA: returns {24'd0, rx_byte} and clears rx_valid on the accepted cycle.
- Read STATUS: returns {28'd0, hold_cs, wcol, rx_valid, busy}.
- data_out is combinational from registers when sel & ~rdWR; otherwise 0.
- FSM states:
  - IDLE: SCK=0. On start → SETUP.
  - SETUP: nCS=0, MOSI=bit7, wait CLK_DIV cycles → HIGH.
  - HIGH: SCK=1. Sample MISO into bit0 on entry. Wait CLK_DIV → LOW.
  - LOW: SCK=0. Shift left and drive the next bit on MOSI. Wait CLK_DIV. After 8 bits → FINISH, else → HIGH.
  - FINISH: wait CLK_DIV. Set nCS=~hold_cs, copy rx into rx_byte, set rx_valid=1 → IDLE.
- If rx_valid is already 1 at transfer end, rx_byte is overwritten. There is no overrun flag.

## Timing
- Reset values: SCK=0, MOSI=0, nCS=1, busy=0, data_out=0, rx_byte=0, hold_cs=0, wcol=0, rx_valid=0. FSM goes to IDLE and the divider counter to 0.
- busy rises on the cycle after the accepted DATA write.
- busy stays high for exactly 18×CLK_DIV cycles (SETUP N, 8 HIGH + 8 LOW phases of N each, FINISH N).
- The first SCK rising edge occurs CLK_DIV cycles after nCS falls.
- MOSI changes only on SCK falling edges (or on SETUP entry). MISO is sampled on the clk edge that raises SCK.
- rx_valid and rx_byte update in the same cycle busy falls.
- A new DATA write accepted in the cycle busy falls starts the next transfer.
- Reset mid-transfer: on the next clk edge, all outputs return to their reset values with no partial-byte effects. hold_cs is also cleared.
- Simultaneous events: a STATUS read and a wcol set in the same cycle return the old wcol; the set wins.

## Structure
- Package mips_spi_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, FINISH);
  - register offsets;
  - STATUS bit indices;
  - the SPI byte width (8).
- Sub-module spi_clk_div: a counter that reloads to CLK_DIV-1 and emits a one-cycle tick. The FSM advances only on tick; the counter is cleared on rst and on start.

## Test plan
- Reset → SCK=0, nCS=1, MOSI=0, busy=0; a STATUS read returns 0.
- CLK_DIV=2, write DATA 0xA5, slave model returns 0x3C → MOSI on SCK rises = 1,0,1,0,0,1,0,1; busy high for 36 cycles; STATUS=0x2; DATA read=0x3C, then STATUS=0x0.
- Write DATA 0x11 while busy with 0xA5 → MOSI stream is unchanged, STATUS.wcol=1; the next accepted write clears wcol.
- CTRL=1, then bytes 0x01 and 0x02 back-to-back → nCS low continuously across both; CTRL=0 → nCS high one cycle later.
- rst asserted during the 4th SCK high phase → next cycle nCS=1, SCK=0, busy=0, rx_valid=0.
- DATA write held for 5 cycles → exactly one transfer; wcol stays 0.

Source files
------------

// File: rtl/mips_spi_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mips_spi_pkg
// Purpose  : Shared types and constants for the memory-mapped SPI master.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package mips_spi_pkg;

    localparam int c_SPI_BYTE_W = 8;

    // ADDR[2] offsets within the block's address pair
    localparam logic c_REG_DATA = 1'b0;
    localparam logic c_REG_CTRL = 1'b1;

    localparam int c_STAT_BUSY     = 0;
    localparam int c_STAT_RX_VALID = 1;
    localparam int c_STAT_WCOL     = 2;
    localparam int c_STAT_HOLD_CS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FINISH = 3'd4
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_spi_master_clk_div.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : spi_clk_div
// Purpose  : Phase timer; emits a one-cycle tick every CLK_DIV enabled cycles.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_TERM) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = en && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/mips_spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mips_spi_master
// Purpose  : CPU-visible SPI mode-0 master, one byte per transfer, MSB first.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mips_spi_master
    import mips_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rdWR,
    input  logic        reg_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        nCS,
    output logic        busy
);

    // Access kinds: [0] wr DATA, [1] wr CTRL, [2] rd DATA, [3] rd STATUS
    logic [3:0] w_kind;
    logic [3:0] r_kind_prev;
    logic [3:0] w_acc;

    spi_state_e r_state;
    spi_state_e w_next;

    logic                    w_tick;
    logic                    w_start;
    logic                    w_sample;
    logic                    w_shift;
    logic                    w_bit_inc;
    logic                    w_done;
    logic                    w_busy;
    logic                    w_sck;
    logic [2:0]              r_bit_cnt;
    logic [c_SPI_BYTE_W-1:0] r_shift;
    logic [c_SPI_BYTE_W-1:0] r_rx;
    logic [c_SPI_BYTE_W-1:0] r_rx_byte;
    logic                    r_rx_valid;
    logic                    r_wcol;
    logic                    r_hold_cs;
    logic                    r_ncs;
    logic                    w_unused_data;

    assign w_kind = {sel & ~rdWR &  reg_addr,
                     sel & ~rdWR & ~reg_addr,
                     sel &  rdWR &  reg_addr,
                     sel &  rdWR & ~reg_addr};
    assign w_acc  = w_kind & ~r_kind_prev;

    assign w_start       = w_acc[0] && (r_state == ST_IDLE);
    assign w_unused_data = &{1'b0, data_in[31:c_SPI_BYTE_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kind_prev <= '0;
        end else begin
            r_kind_prev <= w_kind;
        end
    end

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .en   (w_busy),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_SETUP;
            ST_SETUP:  if (w_tick)  w_next = ST_HIGH;
            ST_HIGH:   if (w_tick)  w_next = ST_LOW;
            ST_LOW:    if (w_tick)  w_next = (r_bit_cnt == 3'd7) ? ST_FINISH : ST_HIGH;
            ST_FINISH: if (w_tick)  w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Strobes fire on the edge that enters the named phase
    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_sck     = (r_state == ST_HIGH);
        w_sample  = w_tick && ((r_state == ST_SETUP) ||
                               ((r_state == ST_LOW) && (r_bit_cnt != 3'd7)));
        w_shift   = w_tick && (r_state == ST_HIGH);
        w_bit_inc = w_tick && (r_state == ST_LOW);
        w_done    = w_tick && (r_state == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_wcol     <= 1'b0;
            r_hold_cs  <= 1'b0;
            r_ncs      <= 1'b1;
        end else begin
            if (w_start) begin
                r_shift   <= data_in[c_SPI_BYTE_W-1:0];
                r_bit_cnt <= '0;
                r_wcol    <= 1'b0;
                r_ncs     <= 1'b0;
            end else if (w_acc[0]) begin
                r_wcol <= 1'b1;
            end
            if (w_sample) begin
                r_rx <= {r_rx[c_SPI_BYTE_W-2:0], MISO};
            end
            if (w_shift) begin
                r_shift <= {r_shift[c_SPI_BYTE_W-2:0], 1'b0};
            end
            if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_acc[1]) begin
                r_hold_cs <= data_in[0];
                if (!data_in[0] && !w_busy) begin
                    r_ncs <= 1'b1;
                end
            end
            if (w_acc[2]) begin
                r_rx_valid <= 1'b0;
            end
            // A completing transfer overrides a same-cycle DATA read clear
            if (w_done) begin
                r_rx_byte  <= r_rx;
                r_rx_valid <= 1'b1;
                r_ncs      <= ~r_hold_cs;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (sel && !rdWR) begin
            if (reg_addr == c_REG_CTRL) begin
                data_out[c_STAT_BUSY]     = w_busy;
                data_out[c_STAT_RX_VALID] = r_rx_valid;
                data_out[c_STAT_WCOL]     = r_wcol;
                data_out[c_STAT_HOLD_CS]  = r_hold_cs;
            end else begin
                data_out[c_SPI_BYTE_W-1:0] = r_rx_byte;
            end
        end
    end

    assign SCK  = w_sck;
    assign MOSI = r_shift[c_SPI_BYTE_W-1];
    assign nCS  = r_ncs;
    assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mips_spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mips_spi_master
// Purpose  : Self-checking bench for mips_spi_master with a mode-0 slave model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mips_spi_master;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rdWR = 1'b0;
    logic        reg_addr = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        SCK, MOSI, nCS, busy;
    logic        MISO = 1'b0;

    always #5 clk = ~clk;

    mips_spi_master #(.CLK_DIV(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rdWR     (rdWR),
        .reg_addr (reg_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .nCS      (nCS),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the software-visible flags
    logic m_hold = 1'b0, m_wcol = 1'b0, m_rxv = 1'b0;

    logic       prev_sck = 1'b0, prev_busy = 1'b0, prev_ncs = 1'b1;
    logic [7:0] mosi_byte = '0, slave_sr = '0;
    int         mosi_bits = 0, busy_cnt = 0, busy_rises = 0, sck_rises = 0;
    int         ncs_high = 0, cyc = 0, t_ncs = 0, t_sck = 0;
    bit         mon_ncs = 1'b0;

    // Wire-level observer plus slave: slave shifts out MSB first on SCK falls
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (busy && !prev_busy) busy_rises++;
        if (!nCS && prev_ncs) t_ncs = cyc;
        if (SCK && !prev_sck) begin
            if (mosi_bits == 0) t_sck = cyc;
            mosi_byte = {mosi_byte[6:0], MOSI};
            mosi_bits++;
            sck_rises++;
        end
        if (!SCK && prev_sck) begin
            slave_sr = {slave_sr[6:0], 1'b0};
            MISO     = slave_sr[7];
        end
        if (mon_ncs && nCS) ncs_high++;
        prev_sck  = SCK;
        prev_busy = busy;
        prev_ncs  = nCS;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {28'd0, m_hold, m_wcol, m_rxv, 1'b0};
    endfunction

    task automatic bus_write(input logic addr, input logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; rdWR = 1'b1; reg_addr = addr; data_in = d;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic bus_read(input logic addr, output logic [31:0] d);
        @(posedge clk); #1;
        sel = 1'b1; rdWR = 1'b0; reg_addr = addr;
        @(negedge clk);
        d = data_out;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic arm_slave(input logic [7:0] srx);
        slave_sr   = srx;
        MISO       = srx[7];
        mosi_bits  = 0;
        mosi_byte  = '0;
        busy_cnt   = 0;
        busy_rises = 0;
        sck_rises  = 0;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] srx);
        logic [31:0] r;
        r = $urandom;
        @(posedge clk); #1;
        arm_slave(srx);
        sel = 1'b1; rdWR = 1'b1; reg_addr = 1'b0; data_in = {r[31:8], tx};
        @(posedge clk); #1;
        sel = 1'b0;
        m_wcol = 1'b0;
        @(negedge clk);
        check("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("xfer_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_xfer(input logic [7:0] tx, input logic [7:0] srx);
        logic [31:0] d;
        check("mosi_bits", mosi_bits, 8);
        check("mosi_byte", {24'd0, mosi_byte}, {24'd0, tx});
        check("busy_cycles", busy_cnt, 18 * N);
        m_rxv = 1'b1;
        bus_read(1'b1, d);
        check("status_done", d, exp_status());
        bus_read(1'b0, d);
        check("rx_data", d, {24'd0, srx});
        m_rxv = 1'b0;
        bus_read(1'b1, d);
        check("status_read", d, exp_status());
    endtask

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] srx;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  tx, srx;
        int          n;

        vecs[0] = '{tx: 8'hA5, srx: 8'h3C};
        vecs[1] = '{tx: 8'hFF, srx: 8'h00};
        vecs[2] = '{tx: 8'h00, srx: 8'hFF};
        vecs[3] = '{tx: 8'h81, srx: 8'h7E};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sck",  {31'd0, SCK},  32'd0);
        check("rst_ncs",  {31'd0, nCS},  32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        bus_read(1'b1, d);
        check("rst_status", d, 32'd0);

        for (int i = 0; i < 4; i++) begin
            start_xfer(vecs[i].tx, vecs[i].srx);
            wait_done();
            check("ncs_to_sck", t_sck - t_ncs, N);
            check_xfer(vecs[i].tx, vecs[i].srx);
        end

        for (int i = 0; i < 6; i++) begin
            tx  = 8'($urandom);
            srx = 8'($urandom);
            start_xfer(tx, srx);
            wait_done();
            check_xfer(tx, srx);
        end

        // Write collision: second DATA write during a transfer is dropped
        start_xfer(8'hA5, 8'h3C);
        repeat (5) @(negedge clk);
        bus_write(1'b0, 32'h11);
        m_wcol = 1'b1;
        wait_done();
        check("wcol_mosi", {24'd0, mosi_byte}, 32'hA5);
        check("wcol_busy_cycles", busy_cnt, 18 * N);
        m_rxv = 1'b1;
        bus_read(1'b1, d);
        check("wcol_status", d, exp_status());
        start_xfer(8'h5A, 8'hC3);
        wait_done();
        check_xfer(8'h5A, 8'hC3);

        // hold_cs keeps the slave selected across back-to-back bytes
        bus_write(1'b1, 32'h1);
        m_hold = 1'b1;
        @(negedge clk);
        check("hold_idle_ncs", {31'd0, nCS}, 32'd1);
        start_xfer(8'h01, 8'h10);
        ncs_high = 0;
        mon_ncs  = 1'b1;
        wait_done();
        check("hold1_mosi", {24'd0, mosi_byte}, 32'h01);
        start_xfer(8'h02, 8'h20);
        wait_done();
        mon_ncs = 1'b0;
        check("hold_ncs_high_cycles", ncs_high, 0);
        check_xfer(8'h02, 8'h20);
        check("hold_ncs_after", {31'd0, nCS}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b1; rdWR = 1'b1; reg_addr = 1'b1; data_in = 32'h0;
        @(negedge clk);
        check("ctrl0_ncs_before", {31'd0, nCS}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0;
        m_hold = 1'b0;
        @(negedge clk);
        check("ctrl0_ncs_after", {31'd0, nCS}, 32'd1);

        // Level-held write must start exactly one transfer
        @(posedge clk); #1;
        arm_slave(8'h96);
        sel = 1'b1; rdWR = 1'b1; reg_addr = 1'b0; data_in = 32'h0000_0069;
        repeat (5) @(posedge clk);
        #1 sel = 1'b0;
        m_wcol = 1'b0;
        wait_done();
        check("held_busy_rises", busy_rises, 1);
        check_xfer(8'h69, 8'h96);

        // Reset during the 4th SCK high phase
        bus_write(1'b1, 32'h1);
        m_hold = 1'b1;
        start_xfer(8'hA5, 8'h3C);
        n = 0;
        while (sck_rises < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("sck4_reached", sck_rises, 4);
        check("sck4_high", {31'd0, SCK}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hold = 1'b0; m_wcol = 1'b0; m_rxv = 1'b0;
        @(negedge clk);
        check("mrst_ncs",  {31'd0, nCS},  32'd1);
        check("mrst_sck",  {31'd0, SCK},  32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_mosi", {31'd0, MOSI}, 32'd0);
        bus_read(1'b1, d);
        check("mrst_status", d, exp_status());
        bus_read(1'b0, d);
        check("mrst_rx_byte", d, 32'd0);

        for (int i = 0; i < 3; i++) begin
            tx  = 8'($urandom);
            srx = 8'($urandom);
            start_xfer(tx, srx);
            wait_done();
            check_xfer(tx, srx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
